// File: rtl/dds_pkg.sv
// Shared DDS definitions: waveform codes for the output mux and the
// wave-select controller state encoding.
package dds_pkg;

  localparam int unsigned NUM_WAVES = 5;

  localparam logic [2:0] WAVE_SINE     = 3'd0;
  localparam logic [2:0] WAVE_SAW      = 3'd1;
  localparam logic [2:0] WAVE_PULSE    = 3'd2;
  localparam logic [2:0] WAVE_TRIANGLE = 3'd3;
  localparam logic [2:0] WAVE_NOISE    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_AUTO    = 2'd2
  } wave_state_t;

endpackage

// File: rtl/wave_sel_ctrl.sv
// Waveform select controller: applies host commands only on a phase wrap so
// the DDS output never switches mid-period, with an optional auto-cycle mode.
module wave_sel_ctrl #(
  parameter int unsigned NUM_WAVES = 5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_sel,
  input  logic             cmd_auto,
  input  logic [CNT_W-1:0] cmd_periods,
  input  logic             phase_wrap,
  output logic [2:0]       sel,
  output logic             switch_pulse,
  output logic             busy
);
  import dds_pkg::*;

  localparam logic [2:0]       LAST_WAVE = 3'(NUM_WAVES - 1);
  localparam logic [3:0]       WAVE_LIM  = 4'(NUM_WAVES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  wave_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_per;
  logic [2:0]       lat_sel;
  logic             lat_auto;
  logic             accept;

  assign cmd_ready = (state != ST_PENDING);
  assign busy      = (state == ST_PENDING);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sel          <= WAVE_SINE;
      switch_pulse <= 1'b0;
      cnt          <= '0;
      lat_sel      <= '0;
      lat_auto     <= 1'b0;
      lat_per      <= '0;
    end else begin
      switch_pulse <= 1'b0;
      // Acceptance takes priority so a coincident wrap neither applies nor advances.
      if (accept) begin
        lat_sel  <= ({1'b0, cmd_sel} >= WAVE_LIM) ? WAVE_SINE : cmd_sel;
        lat_auto <= cmd_auto;
        lat_per  <= (cmd_periods == '0) ? ONE : cmd_periods;
        cnt      <= '0;
        state    <= ST_PENDING;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_PENDING: begin
            if (phase_wrap) begin
              sel          <= lat_sel;
              switch_pulse <= 1'b1;
              cnt          <= '0;
              state        <= lat_auto ? ST_AUTO : ST_IDLE;
            end
          end
          ST_AUTO: begin
            if (phase_wrap) begin
              if (cnt == lat_per - ONE) begin
                cnt          <= '0;
                sel          <= (sel == LAST_WAVE) ? WAVE_SINE : sel + 3'd1;
                switch_pulse <= 1'b1;
              end else begin
                cnt <= cnt + ONE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_sel_ctrl.sv
// Self-checking bench for wave_sel_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the command/wrap rules.
module tb_wave_sel_ctrl;

  localparam int NUM_WAVES = 5;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_sel = '0;
  logic             cmd_auto = 1'b0;
  logic [CNT_W-1:0] cmd_periods = '0;
  logic             phase_wrap = 1'b0;
  logic [2:0]       sel;
  logic             switch_pulse;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // Behavioural model
  bit m_pending, m_auto, m_doauto, m_pulse;
  int m_sel, m_cnt, m_code, m_per;

  wave_sel_ctrl #(.NUM_WAVES(NUM_WAVES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_auto(cmd_auto), .cmd_periods(cmd_periods),
    .phase_wrap(phase_wrap), .sel(sel), .switch_pulse(switch_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pending = 0; m_auto = 0; m_doauto = 0; m_pulse = 0;
    m_sel = 0; m_cnt = 0; m_code = 0; m_per = 0;
  endtask

  task automatic model_update();
    bit accept;
    accept  = cmd_valid && !m_pending;
    m_pulse = 0;
    if (accept) begin
      m_code    = (int'(cmd_sel) >= NUM_WAVES) ? 0 : int'(cmd_sel);
      m_per     = (cmd_periods == 0) ? 1 : int'(cmd_periods);
      m_doauto  = cmd_auto;
      m_pending = 1;
      m_auto    = 0;
      m_cnt     = 0;
    end else if (m_pending) begin
      if (phase_wrap) begin
        m_sel     = m_code;
        m_pulse   = 1;
        m_pending = 0;
        m_auto    = m_doauto;
        m_cnt     = 0;
      end
    end else if (m_auto && phase_wrap) begin
      m_cnt++;
      if (m_cnt == m_per) begin
        m_cnt   = 0;
        m_sel   = (m_sel + 1) % NUM_WAVES;
        m_pulse = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_update();
    #1;
  endtask

  task automatic drive(input bit v, input int s, input bit a, input int p, input bit w);
    cmd_valid   = v;
    cmd_sel     = 3'(s);
    cmd_auto    = a;
    cmd_periods = CNT_W'(p);
    phase_wrap  = w;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    step();
    step();
    checks++;
    if (sel !== 3'd0 || switch_pulse !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_hold sel=%0d pulse=%0b busy=%0b ready=%0b want 0/0/0/1",
               sel, switch_pulse, busy, cmd_ready);
    end
    rst = 1'b0;
    step();
    checks++;
    if (sel !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release sel=%0d busy=%0b ready=%0b want 0/0/1", sel, busy, cmd_ready);
    end
  endtask

  task automatic test_fixed();
    bit ok;
    drive(1, 2, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy !== 1'b1 || cmd_ready !== 1'b0 || sel !== 3'd0 || switch_pulse !== 1'b0) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fixed_pending busy=%0b ready=%0b sel=%0d want 1/0/0", busy, cmd_ready, sel);
    end
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (sel !== 3'd2 || switch_pulse !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL fixed_apply sel=%0d pulse=%0b busy=%0b want 2/1/0", sel, switch_pulse, busy);
    end
    step();
    checks++;
    if (sel !== 3'd2 || switch_pulse !== 1'b0) begin
      failures++;
      $display("FAIL fixed_after sel=%0d pulse=%0b want 2/0", sel, switch_pulse);
    end
  endtask

  task automatic test_invalid_and_same_code();
    drive(1, 6, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (sel !== 3'd0 || switch_pulse !== 1'b1) begin
      failures++;
      $display("FAIL invalid_code sel=%0d pulse=%0b want 0/1", sel, switch_pulse);
    end
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (sel !== 3'd0 || switch_pulse !== 1'b1) begin
      failures++;
      $display("FAIL same_code sel=%0d pulse=%0b want 0/1", sel, switch_pulse);
    end
  endtask

  task automatic test_auto();
    int exp_seq[13] = '{3, 4, 4, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
    int prev;
    drive(1, 3, 1, 2, 0);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    checks++;
    if (sel !== 3'd3 || switch_pulse !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL auto_apply sel=%0d pulse=%0b busy=%0b want 3/1/0", sel, switch_pulse, busy);
    end
    prev = 3;
    for (int i = 0; i < 13; i++) begin
      step();
      checks++;
      if (sel !== 3'(exp_seq[i]) || switch_pulse !== (exp_seq[i] != prev)) begin
        failures++;
        $display("FAIL auto_seq wrap=%0d sel=%0d pulse=%0b want %0d/%0b",
                 i + 1, sel, switch_pulse, exp_seq[i], exp_seq[i] != prev);
      end
      prev = exp_seq[i];
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_periods_zero();
    int exp_s;
    drive(1, 1, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (sel !== 3'd4 || busy !== 1'b1 || switch_pulse !== 1'b0) begin
      failures++;
      $display("FAIL auto_stop sel=%0d busy=%0b want 4/1", sel, busy);
    end
    drive(0, 0, 0, 0, 1);
    step();
    exp_s = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_s = (exp_s + 1) % NUM_WAVES;
      checks++;
      if (sel !== 3'(exp_s) || switch_pulse !== 1'b1) begin
        failures++;
        $display("FAIL periods_zero wrap=%0d sel=%0d pulse=%0b want %0d/1", i, sel, switch_pulse, exp_s);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_same_cycle();
    logic [2:0] held;
    bit ok;
    held = sel;
    drive(1, 3, 0, 0, 1);
    step();
    checks++;
    if (sel !== held || switch_pulse !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL auto_cmd_wrap sel=%0d pulse=%0b busy=%0b want %0d/0/1", sel, switch_pulse, busy, held);
    end
    drive(1, 4, 1, 0, 0);
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || sel !== held) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL pending_hold ready=%0b busy=%0b sel=%0d want 0/1/%0d", cmd_ready, busy, sel, held);
    end
    drive(0, 0, 0, 0, 1);
    step();
    checks++;
    if (sel !== 3'd3 || switch_pulse !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pending_apply sel=%0d pulse=%0b busy=%0b want 3/1/0", sel, switch_pulse, busy);
    end
    drive(1, 1, 0, 0, 1);
    step();
    checks++;
    if (sel !== 3'd3 || switch_pulse !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL idle_cmd_wrap sel=%0d pulse=%0b busy=%0b want 3/0/1", sel, switch_pulse, busy);
    end
    drive(0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    checks++;
    if (sel !== 3'd1 || switch_pulse !== 1'b1) begin
      failures++;
      $display("FAIL idle_apply sel=%0d pulse=%0b want 1/1", sel, switch_pulse);
    end
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (sel !== 3'd1 || switch_pulse !== 1'b0 || busy !== 1'b0) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_wrap_ignored sel=%0d pulse=%0b want 1/0", sel, switch_pulse);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (sel !== 3'd0 || switch_pulse !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_async sel=%0d pulse=%0b busy=%0b ready=%0b want 0/0/0/1",
               tag, sel, switch_pulse, busy, cmd_ready);
    end
    drive(0, 0, 0, 0, 1);
    step();
    rst = 1'b0;
    step();
    checks++;
    if (sel !== 3'd0 || switch_pulse !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_release sel=%0d pulse=%0b busy=%0b ready=%0b want 0/0/0/1",
               tag, sel, switch_pulse, busy, cmd_ready);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 2, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    mid_reset("rst_pending");
    drive(1, 2, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (sel !== 3'd3) begin
      failures++;
      $display("FAIL auto_before_rst sel=%0d want 3", sel);
    end
    mid_reset("rst_auto");
  endtask

  task automatic test_random();
    int per;
    for (int i = 0; i < 600; i++) begin
      per = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            per, $urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if (sel !== 3'(m_sel) || switch_pulse !== m_pulse || busy !== m_pending || cmd_ready !== !m_pending) begin
        failures++;
        $display("FAIL random cyc=%0d sel=%0d pulse=%0b busy=%0b ready=%0b want %0d/%0b/%0b/%0b",
                 i, sel, switch_pulse, busy, cmd_ready, m_sel, m_pulse, m_pending, !m_pending);
      end
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed();
    test_invalid_and_same_code();
    test_auto();
    test_periods_zero();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
